// File: rtl/twiddle_seq_pkg.sv
// ============================================================================
// twiddle_seq_pkg : shared FSM encodings and twiddle/exponent helper functions
// Rev 1.0
// ============================================================================
`default_nettype none

package twiddle_seq_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   localparam real TW_PI = 3.14159265358979323846;

   function automatic int clog2_min1(input int v);
      int r;
      for (r = 0; (1 << r) < v; r++) begin
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Round half away from zero, as the coefficient table is defined
   function automatic int tw_round(input real x);
      if (x >= 0.0)
         return $rtoi(x + 0.5);
      else
         return -$rtoi(-x + 0.5);
   endfunction

   function automatic int tw_re(input int k, input int n, input int nbits);
      real amp;
      amp = real'((1 << (nbits - 1)) - 1);
      return tw_round(amp * $cos(2.0 * TW_PI * real'(k) / real'(n)));
   endfunction

   function automatic int tw_im(input int k, input int n, input int nbits);
      real amp;
      amp = real'((1 << (nbits - 1)) - 1);
      return tw_round(-amp * $sin(2.0 * TW_PI * real'(k) / real'(n)));
   endfunction

   // n is a power of two, so the modulo reduces to a mask
   function automatic int tw_exp(input int j, input int s, input int n);
      return (j & ((n >> (s + 1)) - 1)) << s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/twiddle_seq_if.sv
// ============================================================================
// twiddle_seq_if : control request and coefficient stream of the sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

interface twiddle_seq_if #(
   parameter int NBITS = 11,
   parameter int N     = 128,
   parameter int LANES = 4
);
   localparam int LOG2N = $clog2(N);
   localparam int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1;

   logic                       start;
   logic [SW-1:0]              stage;
   logic                       inverse;
   logic                       busy;
   logic                       err;
   logic [LANES*2*NBITS-1:0]   coeff_out;
   logic                       out_valid;
   logic                       out_ready;
   logic                       last;
   logic                       done;

   modport master (
      output start, stage, inverse, out_ready,
      input  busy, err, coeff_out, out_valid, last, done
   );

   modport slave (
      input  start, stage, inverse, out_ready,
      output busy, err, coeff_out, out_valid, last, done
   );
endinterface

`default_nettype wire

// File: rtl/twiddle_seq_rom.sv
// ============================================================================
// twiddle_seq_rom : combinational W[k] table with one read port per lane
// Rev 1.0
// ============================================================================
`default_nettype none

module twiddle_seq_rom
   import twiddle_seq_pkg::*;
#(
   parameter int NBITS = 11,
   parameter int N     = 128,
   parameter int LANES = 4,
   parameter int KW    = clog2_min1(N / 2)
) (
   input  wire logic [LANES*KW-1:0]        k,
   output logic      [LANES*2*NBITS-1:0]   w
);

   logic [2*NBITS-1:0] w_tab [N/2];

   // Table entries are elaboration-time constants, so this folds to logic
   for (genvar gk = 0; gk < N / 2; gk++) begin : g_tab
      localparam int RE = tw_re(gk, N, NBITS);
      localparam int IM = tw_im(gk, N, NBITS);
      assign w_tab[gk] = {NBITS'(RE), NBITS'(IM)};
   end

   for (genvar gl = 0; gl < LANES; gl++) begin : g_port
      assign w[gl*2*NBITS +: 2*NBITS] = w_tab[k[gl*KW +: KW]];
   end

endmodule

`default_nettype wire

// File: rtl/twiddle_seq.sv
// ============================================================================
// twiddle_seq : per-stage twiddle sequencer, LANES coefficients per beat
// Rev 1.0
// ============================================================================
`default_nettype none

module twiddle_seq
   import twiddle_seq_pkg::*;
#(
   parameter int NBITS = 11,
   parameter int N     = 128,
   parameter int LANES = 4
) (
   input  wire logic       clk,
   input  wire logic       rst,
   twiddle_seq_if.slave    bus
);

   localparam int LOG2N = $clog2(N);
   localparam int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1;
   localparam int BEATS = N / (2 * LANES);
   localparam int BW    = clog2_min1(BEATS);
   localparam int KW    = clog2_min1(N / 2);
   localparam int CW    = LANES * 2 * NBITS;

   logic [1:0]     r_state;
   logic [SW-1:0]  r_stage;
   logic           r_inv;
   logic [BW-1:0]  r_beat;
   logic           r_busy;
   logic           r_err;
   logic [CW-1:0]  r_coeff;
   logic           r_valid;
   logic           r_last;
   logic           r_done;

   logic [BW-1:0]     w_idx;
   logic [LANES*KW-1:0] w_k;
   logic [CW-1:0]     w_rom;
   logic [CW-1:0]     w_beat;
   logic              w_last_idx;
   logic              w_stage_ok;

   // Beat being prepared: 0 while loading, otherwise the one after the shown beat
   always_comb begin
      w_idx = (r_state == ST_LOAD) ? '0 : r_beat + BW'(1);
      w_k   = '0;
      for (int l = 0; l < LANES; l++)
         w_k[l*KW +: KW] = KW'(tw_exp(int'(w_idx) * LANES + l, int'(r_stage), N));
   end

   twiddle_seq_rom #(
      .NBITS (NBITS),
      .N     (N),
      .LANES (LANES),
      .KW    (KW)
   ) u_rom (
      .k (w_k),
      .w (w_rom)
   );

   always_comb begin
      w_beat = w_rom;
      if (r_inv) begin
         for (int l = 0; l < LANES; l++)
            w_beat[l*2*NBITS +: NBITS] = NBITS'(0) - w_rom[l*2*NBITS +: NBITS];
      end
   end

   assign w_last_idx = (w_idx == BW'(BEATS - 1));
   assign w_stage_ok = (32'(bus.stage) < LOG2N);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_stage <= '0;
         r_inv   <= 1'b0;
         r_beat  <= '0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
         r_coeff <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_err  <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  if (w_stage_ok) begin
                     r_stage <= bus.stage;
                     r_inv   <= bus.inverse;
                     r_busy  <= 1'b1;
                     r_beat  <= '0;
                     r_state <= ST_LOAD;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               r_coeff <= w_beat;
               r_last  <= w_last_idx;
               r_valid <= 1'b1;
               r_beat  <= '0;
               r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (r_valid && bus.out_ready) begin
                  if (r_last) begin
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_beat  <= '0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_beat  <= w_idx;
                     r_coeff <= w_beat;
                     r_last  <= w_last_idx;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.err       = r_err;
   assign bus.coeff_out = r_coeff;
   assign bus.out_valid = r_valid;
   assign bus.last      = r_last;
   assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_twiddle_seq.sv
// ============================================================================
// tb_twiddle_seq : directed self-checking bench for twiddle_seq
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_twiddle_seq;

   localparam int NBITS = 11;
   localparam int N     = 128;
   localparam int LANES = 4;
   localparam int SW    = 3;
   localparam int BEATS = 16;
   localparam int TW    = 2 * NBITS;
   localparam int CW    = LANES * TW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   twiddle_seq_if #(.NBITS(NBITS), .N(N), .LANES(LANES)) bus ();

   twiddle_seq #(.NBITS(NBITS), .N(N), .LANES(LANES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [CW-1:0] cap_c [64];
   logic          cap_l [64];
   int            n_acc, lat, stalls;
   bit            tmo, done_seen, done_idle, stable;

   logic [TW-1:0] ONE, W32_FWD, W32_INV;

   function automatic int rnd(input real x);
      if (x >= 0.0) return int'($floor(x + 0.5));
      return -int'($floor(-x + 0.5));
   endfunction

   function automatic logic [TW-1:0] model_tw(input int k, input bit inv);
      real a;
      int  re, im;
      a  = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
      re = rnd(1023.0 * $cos(a));
      im = rnd(-1023.0 * $sin(a));
      if (inv) im = -im;
      return {NBITS'(re), NBITS'(im)};
   endfunction

   function automatic logic [CW-1:0] model_beat(input int b, input int s, input bit inv);
      logic [CW-1:0] v;
      int j, k;
      v = '0;
      for (int l = 0; l < LANES; l++) begin
         j = b * LANES + l;
         k = (j % (N >> (s + 1))) * (1 << s);
         v[l*TW +: TW] = model_tw(k, inv);
      end
      return v;
   endfunction

   // Runs one pass from a sample point; optional stall of stall_len cycles at beat stall_beat
   task automatic collect(input int s, input bit inv, input int stall_beat, input int stall_len);
      int            cyc, sl;
      bit            acc, was_last;
      logic [CW-1:0] held_c;
      logic          held_l;
      n_acc = 0; lat = -1; tmo = 0; done_seen = 0; done_idle = 0;
      stable = 1; stalls = 0; sl = stall_len; held_c = '0; held_l = 1'b0;
      bus.start = 1'b1; bus.stage = SW'(s); bus.inverse = inv; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.stage = '0; bus.inverse = ~inv;
      cyc = 1;
      forever begin
         if (bus.out_valid && lat < 0) lat = cyc;
         if (bus.out_valid && n_acc == stall_beat && sl > 0) begin
            if (sl == stall_len) begin
               held_c = bus.coeff_out; held_l = bus.last;
            end else if (bus.coeff_out !== held_c || bus.last !== held_l) begin
               stable = 0;
            end
            bus.out_ready = 1'b0; sl--; stalls++;
         end else begin
            bus.out_ready = 1'b1;
         end
         acc      = bus.out_valid && bus.out_ready;
         was_last = bus.last;
         if (acc) begin
            if (stalls > 0 && n_acc == stall_beat && bus.coeff_out !== held_c) stable = 0;
            cap_c[n_acc] = bus.coeff_out; cap_l[n_acc] = bus.last; n_acc++;
         end
         @(posedge clk); #1; cyc++;
         if (acc && was_last) begin
            done_seen = bus.done;
            done_idle = !bus.busy && !bus.out_valid;
            break;
         end
         if (cyc > 200 || n_acc >= 64) begin
            tmo = 1;
            break;
         end
      end
      bus.out_ready = 1'b1;
      bus.inverse   = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0; bus.start = 1'b1; bus.stage = '0; bus.inverse = 1'b0; bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({bus.busy, bus.err, bus.out_valid, bus.last, bus.done} !== 5'b0 || bus.coeff_out !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy/err/valid/last/done=%b coeff=%h, want all 0",
                  {bus.busy, bus.err, bus.out_valid, bus.last, bus.done}, bus.coeff_out);
      end
      rst = 1'b1; bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b valid=%b done=%b, want 0 0 0",
                  bus.busy, bus.out_valid, bus.done);
      end
   endtask

   task automatic test_stage0;
      collect(0, 0, -1, 0);
      n_tests++;
      if (tmo !== 0 || n_acc != BEATS) begin
         n_fail++; $display("FAIL s0_count: got %0d beats (timeout=%0d), want 16", n_acc, tmo);
      end
      n_tests++;
      if (lat != 2) begin
         n_fail++; $display("FAIL s0_latency: got %0d, want 2", lat);
      end
      n_tests++;
      if (cap_c[0][TW-1:0] !== ONE) begin
         n_fail++; $display("FAIL s0_beat0_lane0: got %h, want %h", cap_c[0][TW-1:0], ONE);
      end
      for (int b = 0; b < BEATS; b++) begin
         n_tests++;
         if (cap_c[b] !== model_beat(b, 0, 0) || cap_l[b] !== (b == BEATS - 1)) begin
            n_fail++;
            $display("FAIL s0_beat%0d: got %h last=%b, want %h last=%b",
                     b, cap_c[b], cap_l[b], model_beat(b, 0, 0), (b == BEATS - 1));
         end
      end
      n_tests++;
      if (!done_seen || !done_idle) begin
         n_fail++; $display("FAIL s0_done: done=%0d idle=%0d, want 1 1", done_seen, done_idle);
      end
      @(posedge clk); #1;
      n_tests++;
      if (bus.done !== 1'b0) begin
         n_fail++; $display("FAIL s0_done_width: done=%b one cycle later, want 0", bus.done);
      end
   endtask

   task automatic test_stage6_5;
      collect(6, 0, -1, 0);
      n_tests++;
      if (n_acc != BEATS) begin
         n_fail++; $display("FAIL s6_count: got %0d, want 16", n_acc);
      end
      for (int b = 0; b < BEATS; b++) begin
         n_tests++;
         if (cap_c[b] !== {LANES{ONE}}) begin
            n_fail++; $display("FAIL s6_beat%0d: got %h, want %h", b, cap_c[b], {LANES{ONE}});
         end
      end
      collect(5, 0, -1, 0);
      for (int b = 0; b < BEATS; b++) begin
         n_tests++;
         if (cap_c[b] !== {W32_FWD, ONE, W32_FWD, ONE}) begin
            n_fail++; $display("FAIL s5_beat%0d: got %h, want %h", b, cap_c[b], {W32_FWD, ONE, W32_FWD, ONE});
         end
      end
   endtask

   task automatic test_inverse;
      collect(0, 1, -1, 0);
      n_tests++;
      if (cap_c[8][TW-1:0] !== W32_INV) begin
         n_fail++; $display("FAIL inv_beat8_lane0: got %h, want %h", cap_c[8][TW-1:0], W32_INV);
      end
      for (int b = 0; b < BEATS; b++) begin
         n_tests++;
         if (cap_c[b] !== model_beat(b, 0, 1)) begin
            n_fail++; $display("FAIL inv_beat%0d: got %h, want %h", b, cap_c[b], model_beat(b, 0, 1));
         end
      end
   endtask

   task automatic test_backpressure;
      collect(0, 0, 5, 3);
      n_tests++;
      if (n_acc != BEATS || stalls != 3) begin
         n_fail++; $display("FAIL bp_count: accepted %0d stalls %0d, want 16 3", n_acc, stalls);
      end
      n_tests++;
      if (!stable) begin
         n_fail++; $display("FAIL bp_stable: held beat changed during stall, want stable");
      end
      for (int b = 0; b < BEATS; b++) begin
         n_tests++;
         if (cap_c[b] !== model_beat(b, 0, 0) || cap_l[b] !== (b == BEATS - 1)) begin
            n_fail++; $display("FAIL bp_beat%0d: got %h last=%b, want %h", b, cap_c[b], cap_l[b], model_beat(b, 0, 0));
         end
      end
   endtask

   task automatic test_err;
      bus.stage = SW'(7); bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.stage = '0;
      n_tests++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL err_pulse: err=%b busy=%b valid=%b, want 1 0 0", bus.err, bus.busy, bus.out_valid);
      end
      @(posedge clk); #1;
      n_tests++;
      if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL err_clear: err=%b busy=%b, want 0 0", bus.err, bus.busy);
      end
   endtask

   task automatic test_reset_midpass;
      int cyc, got;
      bit bad;
      cyc = 0; got = 0; bad = 0;
      bus.start = 1'b1; bus.stage = '0; bus.inverse = 1'b0; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      while (got < 9 && cyc < 100) begin
         if (bus.out_valid) got++;
         @(posedge clk); #1; cyc++;
      end
      n_tests++;
      if (got != 9 || bus.out_valid !== 1'b1 || bus.coeff_out !== model_beat(9, 0, 0)) begin
         n_fail++; $display("FAIL rstmid_reach: accepted %0d valid=%b, want 9 1 on beat 9", got, bus.out_valid);
      end
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.last !== 1'b0 || bus.coeff_out !== '0) begin
         n_fail++; $display("FAIL rstmid_abort: busy=%b valid=%b coeff=%h, want 0 0 0", bus.busy, bus.out_valid, bus.coeff_out);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (5) begin
         if (bus.done || bus.out_valid || bus.busy) bad = 1;
         @(posedge clk); #1;
      end
      n_tests++;
      if (bad) begin
         n_fail++; $display("FAIL rstmid_nodone: activity after abort, want idle");
      end
      collect(1, 0, -1, 0);
      n_tests++;
      if (n_acc != BEATS || !done_seen) begin
         n_fail++; $display("FAIL rstmid_rerun: got %0d beats done=%0d, want 16 1", n_acc, done_seen);
      end
      for (int b = 0; b < BEATS; b++) begin
         n_tests++;
         if (cap_c[b] !== model_beat(b, 1, 0)) begin
            n_fail++; $display("FAIL rstmid_beat%0d: got %h, want %h", b, cap_c[b], model_beat(b, 1, 0));
         end
      end
   endtask

   task automatic test_back_to_back;
      collect(2, 0, -1, 0);
      n_tests++;
      if (cap_c[3] !== model_beat(3, 2, 0) || !done_seen) begin
         n_fail++; $display("FAIL b2b_first: beat3=%h done=%0d, want %h 1", cap_c[3], done_seen, model_beat(3, 2, 0));
      end
      // start issued in the cycle done is high
      collect(6, 0, -1, 0);
      n_tests++;
      if (n_acc != BEATS || lat != 2 || cap_c[0] !== {LANES{ONE}}) begin
         n_fail++; $display("FAIL b2b_second: beats=%0d lat=%0d beat0=%h, want 16 2 %h", n_acc, lat, cap_c[0], {LANES{ONE}});
      end
   endtask

   initial begin
      ONE     = {11'd1023, 11'd0};
      W32_FWD = {11'd0, 11'h401};
      W32_INV = {11'd0, 11'd1023};
      bus.start = 1'b0; bus.stage = '0; bus.inverse = 1'b0; bus.out_ready = 1'b1;
      test_reset;
      test_stage0;
      test_stage6_5;
      test_inverse;
      test_backpressure;
      test_err;
      test_reset_midpass;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
